// File: rtl/host_cmd_pkg.sv
// Shared types and constants for the host command sequencer.
package host_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE,
        DISPATCH,
        YAW_WAIT,
        RESPOND
    } state_e;

    localparam logic [7:0] RSP_ACK     = 8'h06;
    localparam logic [7:0] RSP_NAK     = 8'h15;
    localparam logic [7:0] RSP_TIMEOUT = 8'h18;

    localparam logic [15:0] CMD_ENC_OFF = 16'h0001;
    localparam logic [15:0] CMD_ENC_ON  = 16'h0002;
    localparam logic [15:0] CMD_YAW     = 16'h0003;
    localparam logic [15:0] CMD_INVALID = 16'hFFFF;

    localparam int FRAME_W = 1024;

endpackage

// File: rtl/host_cmd_frame_collector.sv
// Assembles host bytes into the decoder frame buffer and watches the
// idle gap between bytes of a partially received frame.
module host_cmd_frame_collector
    import host_cmd_pkg::*;
#(
    parameter int FRAME_BYTES  = 16,
    parameter int BYTE_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,      // drop frame, count and timer
    input  logic               collect,    // bytes are accepted this cycle
    input  logic               timer_en,   // partial frame: idle timer runs
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_full, // last byte accepted this cycle
    output logic               timeout     // idle gap expired this cycle
);

    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);

    logic [FRAME_W-1:0] frame_q;
    logic [CW-1:0]      count_q;
    logic [TW-1:0]      tmr_q;
    logic               accept;

    assign accept     = rx_valid && collect;
    assign frame_full = accept && (count_q == CW'(FRAME_BYTES - 1));
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout    = timer_en && !rx_valid && (tmr_q == TW'(BYTE_TIMEOUT - 1));
    assign frame      = frame_q;

    // Byte write at the current index; bytes past FRAME_BYTES stay zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            frame_q <= '0;
            count_q <= '0;
            tmr_q   <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < FRAME_BYTES; k++)
                    if (count_q == CW'(k))
                        frame_q[8*k +: 8] <= rx_data;
                count_q <= count_q + CW'(1);
                tmr_q   <= '0;
            end else if (timer_en) begin
                tmr_q <= tmr_q + TW'(1);
            end else begin
                tmr_q <= '0;
            end
        end
    end

endmodule

// File: rtl/host_cmd_sequencer.sv
// Host command sequencer: collects a UART command frame, runs the decoder
// handshake, dispatches the decoded command and returns a status byte.
// Optional build macro HOST_CMD_STATS_EN adds response statistics counters.
module host_cmd_sequencer
    import host_cmd_pkg::*;
#(
    parameter int FRAME_BYTES  = 16,
    parameter int BYTE_TIMEOUT = 1000,
    parameter int DEC_TIMEOUT  = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [FRAME_W-1:0] dec_input_data,
    output logic               dec_start,
    input  logic               dec_done,
    input  logic               dec_error,
    input  logic [15:0]        dec_cmd_select,
    input  logic [255:0]       dec_output_data,
    output logic               encrypt_enable,
    output logic               yaw_req,
    output logic [47:0]        yaw_target,
    input  logic               yaw_ack,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               rx_overrun,
    output logic               busy
`ifdef HOST_CMD_STATS_EN
    ,
    output logic [15:0]        stat_ok,
    output logic [15:0]        stat_nak,
    output logic [15:0]        stat_timeout
`endif
);

    localparam int DW = $clog2(DEC_TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [7:0]  rsp_q, rsp_d;
    logic        enc_q, enc_d;
    logic [47:0] yt_q, yt_d;
    logic [DW-1:0] dtmr_q, dtmr_d;
    logic        ovr_q;
    logic        clear, collect, frame_full, byte_to, dexp;
    logic        unused_dec_bits;

    assign unused_dec_bits = ^dec_output_data[255:48];

    assign collect = (state_q == IDLE) || (state_q == COLLECT);
    assign dexp    = (dtmr_q == DW'(DEC_TIMEOUT - 1));

    host_cmd_frame_collector #(
        .FRAME_BYTES  (FRAME_BYTES),
        .BYTE_TIMEOUT (BYTE_TIMEOUT)
    ) u_collect (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .collect    (collect),
        .timer_en   (state_q == COLLECT),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame      (dec_input_data),
        .frame_full (frame_full),
        .timeout    (byte_to)
    );

    assign dec_start      = (state_q == LAUNCH);
    assign yaw_req        = (state_q == YAW_WAIT);
    assign tx_valid       = (state_q == RESPOND);
    assign busy           = (state_q != IDLE);
    assign tx_data        = rsp_q;
    assign yaw_target     = yt_q;
    assign encrypt_enable = enc_q;
    assign rx_overrun     = ovr_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rsp_q   <= '0;
            enc_q   <= 1'b0;
            yt_q    <= '0;
            dtmr_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            enc_q   <= enc_d;
            yt_q    <= yt_d;
            dtmr_q  <= dtmr_d;
            if (rx_valid && !collect)
                ovr_q <= 1'b1;
        end
    end

    // Next-state, handshake timer and dispatch decisions.
    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        enc_d   = enc_q;
        yt_d    = yt_q;
        dtmr_d  = '0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_full)    state_d = LAUNCH;
                else if (rx_valid) state_d = COLLECT;
            end
            COLLECT: begin
                if (frame_full) begin
                    state_d = LAUNCH;
                end else if (byte_to) begin
                    rsp_d   = RSP_TIMEOUT;
                    clear   = 1'b1;
                    state_d = RESPOND;
                end
            end
            LAUNCH: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (!dec_done) begin
                    state_d = WAIT_DONE;
                end else if (dexp) begin
                    rsp_d   = RSP_TIMEOUT;
                    state_d = RESPOND;
                end else begin
                    dtmr_d = dtmr_q + DW'(1);
                end
            end
            WAIT_DONE: begin
                if (dec_done) begin
                    state_d = DISPATCH;
                end else if (dexp) begin
                    rsp_d   = RSP_TIMEOUT;
                    state_d = RESPOND;
                end else begin
                    dtmr_d = dtmr_q + DW'(1);
                end
            end
            DISPATCH: begin
                state_d = RESPOND;
                if (dec_error) begin
                    rsp_d = RSP_NAK;
                end else if (dec_cmd_select == CMD_ENC_OFF) begin
                    enc_d = 1'b0;
                    rsp_d = RSP_ACK;
                end else if (dec_cmd_select == CMD_ENC_ON) begin
                    enc_d = 1'b1;
                    rsp_d = RSP_ACK;
                end else if (dec_cmd_select == CMD_YAW) begin
                    yt_d    = dec_output_data[47:0];
                    state_d = YAW_WAIT;
                end else begin
                    rsp_d = RSP_NAK;
                end
            end
            YAW_WAIT: begin
                if (yaw_ack) begin
                    rsp_d   = RSP_ACK;
                    state_d = RESPOND;
                end else if (dexp) begin
                    rsp_d   = RSP_TIMEOUT;
                    state_d = RESPOND;
                end else begin
                    dtmr_d = dtmr_q + DW'(1);
                end
            end
            RESPOND: begin
                if (tx_ready) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HOST_CMD_STATS_EN
    logic [15:0] ok_q, nak_q, to_q;
    logic        sent;

    assign sent         = (state_q == RESPOND) && tx_ready;
    assign stat_ok      = ok_q;
    assign stat_nak     = nak_q;
    assign stat_timeout = to_q;

    // Saturating counts of status bytes taken by the transmitter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ok_q  <= '0;
            nak_q <= '0;
            to_q  <= '0;
        end else if (sent) begin
            if (rsp_q == RSP_ACK && ok_q != 16'hFFFF)      ok_q  <= ok_q + 16'd1;
            if (rsp_q == RSP_NAK && nak_q != 16'hFFFF)     nak_q <= nak_q + 16'd1;
            if (rsp_q == RSP_TIMEOUT && to_q != 16'hFFFF)  to_q  <= to_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Directed bench for host_cmd_sequencer with a behavioural decoder and a
// scoreboard of expected status bytes.
module tb_host_cmd_sequencer;

    localparam int FB = 16;
    localparam int BT = 40;
    localparam int DT = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [1023:0] dec_input_data;
    logic          dec_start;
    logic          dec_done;
    logic          dec_error;
    logic [15:0]   dec_cmd_select;
    logic [255:0]  dec_output_data;
    logic          encrypt_enable;
    logic          yaw_req;
    logic [47:0]   yaw_target;
    logic          yaw_ack;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          rx_overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    host_cmd_sequencer #(.FRAME_BYTES(FB), .BYTE_TIMEOUT(BT), .DEC_TIMEOUT(DT)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .dec_input_data(dec_input_data), .dec_start(dec_start), .dec_done(dec_done),
        .dec_error(dec_error), .dec_cmd_select(dec_cmd_select),
        .dec_output_data(dec_output_data), .encrypt_enable(encrypt_enable),
        .yaw_req(yaw_req), .yaw_target(yaw_target), .yaw_ack(yaw_ack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_overrun(rx_overrun), .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_code(input logic err, input logic [15:0] cmd);
        if (err) return 8'h15;
        if (cmd == 16'h1 || cmd == 16'h2 || cmd == 16'h3) return 8'h06;
        return 8'h15;
    endfunction

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] f, input int gap);
        send_byte(f[7:0]);
        repeat (gap) @(negedge clk);
        for (int k = 1; k < FB; k++) send_byte(f[8*k +: 8]);
        chk("dec_start_n1", 128'(dec_start), 128'(1));
        chk("frame_lo", dec_input_data[127:0], f);
        chk("frame_hi_zero", 128'(|dec_input_data[1023:128]), 128'(0));
        @(negedge clk);
        chk("dec_start_one_cycle", 128'(dec_start), 128'(0));
    endtask

    // mode 0: normal handshake, 1: done stays high, 2: done never returns
    task automatic decode(input logic err, input logic [15:0] cmd,
                          input logic [255:0] out, input int mode);
        if (mode == 0) sb.push_back(exp_code(err, cmd));
        else           sb.push_back(8'h18);
        if (mode != 1) begin
            dec_done = 1'b0;
            repeat (3) @(negedge clk);
        end
        if (mode == 0) begin
            dec_error       = err;
            dec_cmd_select  = cmd;
            dec_output_data = out;
            dec_done        = 1'b1;
        end
    endtask

    task automatic wait_resp(input int hold, output int lat);
        logic [7:0] e;
        lat = 0;
        while (!tx_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk("tx_valid", 128'(tx_valid), 128'(1));
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("tx_data", 128'(tx_data), 128'(e));
        repeat (hold) @(negedge clk);
        if (hold > 0) chk("tx_hold", 128'({tx_valid, tx_data}), 128'({1'b1, e}));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("idle_after_tx", 128'(busy), 128'(0));
        chk("frame_cleared", dec_input_data[127:0], 128'(0));
    endtask

    task automatic wait_yaw(output int c);
        c = 0;
        while (!yaw_req && c < 50) begin
            @(negedge clk);
            c++;
        end
    endtask

    localparam logic [127:0] FA = 128'h0000000000000001_01FFFFFFFFFFFF01;
    localparam logic [127:0] FY = 128'h0000000000000000_00A6A5A4A3A2A103;
    localparam logic [47:0]  YT = 48'hA6A5A4A3A2A1;

    initial begin
        int lat;
        int c;
        logic seen;
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0; dec_done = 1'b1;
        dec_error = 1'b0; dec_cmd_select = '0; dec_output_data = '0;
        yaw_ack = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 128'({busy, tx_valid, dec_start, encrypt_enable, yaw_req, rx_overrun}), 128'(0));
        chk("rst_tx_yaw", 128'({tx_data, yaw_target}), 128'(0));
        chk("rst_frame", 128'(|dec_input_data), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // encrypt on
        send_frame(FA, 0);
        decode(1'b0, 16'h0002, '0, 0);
        wait_resp(3, lat);
        chk("enc_on", 128'(encrypt_enable), 128'(1));

        // yaw read, held 5 cycles before ack
        send_frame(FY, 0);
        decode(1'b0, 16'h0003, 256'(YT), 0);
        wait_yaw(c);
        for (int i = 0; i < 5; i++) begin
            chk("yaw_hold", 128'({yaw_req, yaw_target}), 128'({1'b1, YT}));
            @(negedge clk);
        end
        yaw_ack = 1'b1;
        @(negedge clk);
        yaw_ack = 1'b0;
        chk("yaw_req_drop", 128'(yaw_req), 128'(0));
        wait_resp(0, lat);

        // decoder error
        send_frame(128'h0F0E0D0C0B0A09080706050403020100, 0);
        decode(1'b1, 16'hFFFF, '0, 0);
        wait_resp(2, lat);
        chk("enc_kept", 128'(encrypt_enable), 128'(1));

        // inter-byte timeout after 3 bytes
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        sb.push_back(8'h18);
        c = 0; seen = 1'b0;
        while (!tx_valid && c < BT + 10) begin
            if (dec_start) seen = 1'b1;
            @(negedge clk);
            c++;
        end
        chk("byte_to_no_start", 128'(seen), 128'(0));
        chk("byte_to_latency_ok", 128'(c >= BT && c <= BT + 2), 128'(1));
        wait_resp(0, lat);
        send_frame(FA, 0);
        decode(1'b0, 16'h0001, '0, 0);
        wait_resp(0, lat);
        chk("enc_off", 128'(encrypt_enable), 128'(0));

        // byte arriving exactly on the expiry cycle is kept
        send_frame(FY, BT - 1);
        decode(1'b0, 16'h0002, '0, 0);
        wait_resp(0, lat);
        chk("enc_on2", 128'(encrypt_enable), 128'(1));
        chk("no_overrun_yet", 128'(rx_overrun), 128'(0));

        // decoder never drops done
        send_frame(FA, 0);
        decode(1'b0, '0, '0, 1);
        wait_resp(0, lat);
        chk("ack_to_latency_ok", 128'(lat >= DT - 1 && lat <= DT + 1), 128'(1));

        // decoder never finishes; stray byte during WAIT_DONE
        send_frame(FA, 0);
        decode(1'b0, '0, '0, 2);
        send_byte(8'h55);
        chk("rx_overrun", 128'(rx_overrun), 128'(1));
        wait_resp(1, lat);
        dec_done = 1'b1;
        chk("enc_unchanged_to", 128'(encrypt_enable), 128'(1));

        // reset in the middle of a yaw request
        send_frame(FY, 0);
        decode(1'b0, 16'h0003, 256'(YT), 0);
        wait_yaw(c);
        chk("yaw_before_reset", 128'(yaw_req), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        chk("mid_rst_outputs", 128'({busy, tx_valid, dec_start, encrypt_enable, yaw_req, rx_overrun}), 128'(0));
        chk("mid_rst_tx_yaw", 128'({tx_data, yaw_target}), 128'(0));
        chk("mid_rst_frame", 128'(|dec_input_data), 128'(0));
        send_frame(FA, 0);
        decode(1'b0, 16'h0002, '0, 0);
        wait_resp(0, lat);
        chk("enc_after_rst", 128'(encrypt_enable), 128'(1));
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/host_cmd_sequencer.md
Name: host_cmd_sequencer

Overview:
- Controller that feeds and sequences host_uart_command_dec.
- Assembles host UART bytes into a command frame, launches the decoder and tracks its start/done handshake with a timeout.
- Dispatches the decoded cmd_select: encryption enable register, or yaw-read request to the device side.
- Returns a one-byte status code to the host UART transmitter.

Parameters:
- FRAME_BYTES, 16, bytes per command frame (1..128); byte k lands in frame[8k+7:8k], unused bytes zero.
- BYTE_TIMEOUT, 1000, idle clk cycles allowed between bytes of a partial frame.
- DEC_TIMEOUT, 256, max clk cycles for any decoder or yaw handshake phase.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received host byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- dec_input_data  out  1024  frame to decoder
- dec_start  out  1  decoder start pulse
- dec_done  in  1  decoder done (high when idle)
- dec_error  in  1  decoder format error
- dec_cmd_select  in  16  decoded command id
- dec_output_data  in  256  decoder payload; [47:0] = yaw target
- encrypt_enable  out  1  encryption enable register
- yaw_req  out  1  yaw-read request (valid)
- yaw_target  out  48  target device for yaw read
- yaw_ack  in  1  yaw request accepted (ready)
- tx_data  out  8  status byte to host
- tx_valid  out  1  status byte valid
- tx_ready  in  1  transmitter accepts tx_data
- rx_overrun  out  1  sticky: byte arrived while not collecting
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values (next posedge clk with reset high, from any state, including mid-operation):
  - state IDLE; all outputs 0, including dec_input_data, dec_start, encrypt_enable, yaw_req, tx_valid, rx_overrun.
  - Byte count and timers cleared.
- State machine:
  - IDLE: rx_valid stores the byte at index 0, count=1 -> COLLECT. If FRAME_BYTES==1 -> LAUNCH.
  - COLLECT:
    - rx_valid stores the byte at index count, count+1; idle timer cleared.
    - Storing the byte with index FRAME_BYTES-1 -> LAUNCH.
    - Idle timer reaching BYTE_TIMEOUT: frame discarded, tx code 0x18 -> RESPOND.
  - LAUNCH: dec_start=1 for exactly one cycle, dec_input_data stable -> WAIT_ACK. Latency: last byte accepted at cycle N, dec_start high at cycle N+1.
  - WAIT_ACK: dec_done==0 -> WAIT_DONE.
  - WAIT_DONE: dec_done==1 -> DISPATCH.
  - Decoder timeout: WAIT_ACK and WAIT_DONE each have a DEC_TIMEOUT counter; expiry -> code 0x18 -> RESPOND.
  - DISPATCH (single cycle), first match wins:
    1. dec_error=1 -> code 0x15.
    2. cmd_select 0x0001 -> encrypt_enable<=0, code 0x06.
    3. cmd_select 0x0002 -> encrypt_enable<=1, code 0x06.
    4. cmd_select 0x0003 -> yaw_target<=dec_output_data[47:0], yaw_req<=1 -> YAW_WAIT.
    5. Anything else (incl. 0xFFFF) -> code 0x15.
  - YAW_WAIT: yaw_req held with yaw_target stable until yaw_ack is sampled high; then yaw_req<=0, code 0x06 -> RESPOND. DEC_TIMEOUT expiry -> yaw_req<=0, code 0x18.
  - RESPOND: tx_valid=1, tx_data held until tx_ready sampled high -> IDLE; frame buffer cleared. No timeout.
- rx_valid outside IDLE/COLLECT: byte dropped, rx_overrun<=1 (sticky until reset).
- rx_valid in COLLECT on the same cycle the idle timer expires: byte accepted, timer cleared; timeout suppressed.
- encrypt_enable changes only in DISPATCH.

Optional Feature:
- HOST_CMD_STATS_EN defined:
  - Adds outputs stat_ok[15:0], stat_nak[15:0], stat_timeout[15:0], counting 0x06/0x15/0x18 responses.
  - Each counter increments when its byte is accepted in RESPOND; saturates at 0xFFFF; cleared by reset.
- Undefined: no ports and no logic.

Decomposition:
- Package host_cmd_pkg:
  - state enum (IDLE, COLLECT, LAUNCH, WAIT_ACK, WAIT_DONE, DISPATCH, YAW_WAIT, RESPOND);
  - response codes RSP_ACK=0x06, RSP_NAK=0x15, RSP_TIMEOUT=0x18;
  - cmd ids CMD_ENC_OFF=0x0001, CMD_ENC_ON=0x0002, CMD_YAW=0x0003, CMD_INVALID=0xFFFF.
- Sub-module host_cmd_frame_collector: byte-index write into the 1024-bit buffer, byte count, inter-byte timer, frame_full/timeout flags. The top level keeps the FSM.

Test Plan:
- 16 bytes {01,FF×6,01,01,00×7} with decoder model returning cmd_select=2 -> one dec_start pulse at N+1, encrypt_enable=1, tx_data=0x06.
- 16 bytes with byte0=03, bytes1–6=A1..A6, decoder output [47:0]=0xA6A5A4A3A2A1 -> yaw_req with yaw_target=0xA6A5A4A3A2A1 held 5 cycles until yaw_ack, then tx_data=0x06.
- Decoder returns error=1, cmd_select=0xFFFF -> tx_data=0x15, encrypt_enable unchanged.
- 3 bytes then silence for BYTE_TIMEOUT cycles -> no dec_start, tx_data=0x18. Next full frame decodes normally.
- Decoder holds done=1 after start -> 0x18 after DEC_TIMEOUT. Byte sent during WAIT_DONE -> rx_overrun=1.
- reset asserted in YAW_WAIT with tx_ready held low in a prior RESPOND -> next cycle all outputs 0, state IDLE, new frame accepted.
